// File: rtl/lms_adapt_ctrl_pkg.sv
// Shared definitions for the LMS adaptation controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lms_ctrl_pkg;

  // Controller states; the encodings are visible on o_state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_TRAIN  = 3'd2,
    ST_TRACK  = 3'd3,
    ST_FROZEN = 3'd4
  } state_t;

  // Largest positive Q16.16 value; the averager's reload and ceiling value.
  localparam logic [31:0] Q16_MAX_POS = 32'h7FFF_FFFF;

  // Default tuning values.
  localparam int AVG_SHIFT_DEF = 4;
  localparam int HOLD_CNT_DEF  = 8;
  localparam int FLUSH_CYC_DEF = 4;

endpackage

// File: rtl/lms_adapt_ctrl_err_avg_lpf.sv
// Leaky average of |error|: abs with saturation, then avg += (|e| - avg) >>> AVG_SHIFT.
// Latency: avg registered, one cycle after en; avg_nxt is the combinational next value.
// Backpressure: none; one update per cycle with en, load_max has priority.
module err_avg_lpf #(
  parameter int NB_DATA   = 32,
  parameter int AVG_SHIFT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               load_max,
  input  logic               en,
  input  logic [NB_DATA-1:0] error,
  output logic [NB_DATA-1:0] avg,
  output logic [NB_DATA-1:0] avg_nxt
);

  localparam logic [NB_DATA-1:0] MAX_POS = {1'b0, {(NB_DATA-1){1'b1}}};
  localparam logic [NB_DATA-1:0] MIN_NEG = {1'b1, {(NB_DATA-1){1'b0}}};

  logic [NB_DATA-1:0]      mag;
  logic signed [NB_DATA:0] diff;
  logic signed [NB_DATA:0] step;
  logic signed [NB_DATA:0] sum;

  // Magnitude, leak step and clamp of the updated average to [0, MAX_POS].
  always_comb begin
    mag = error;
    if (error[NB_DATA-1]) begin
      mag = (error == MIN_NEG) ? MAX_POS : -error;
    end
    diff = $signed({1'b0, mag}) - $signed({1'b0, avg});
    step = diff >>> AVG_SHIFT;
    sum  = $signed({1'b0, avg}) + step;
    if (sum[NB_DATA]) begin
      avg_nxt = '0;
    end else if (sum[NB_DATA-1]) begin
      avg_nxt = MAX_POS;
    end else begin
      avg_nxt = sum[NB_DATA-1:0];
    end
  end

  // Average register: reload to max on flush, otherwise integrate on en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      avg <= '0;
    end else if (load_max) begin
      avg <= MAX_POS;
    end else if (en) begin
      avg <= avg_nxt;
    end
  end

endmodule

// File: rtl/lms_adapt_ctrl.sv
// Sequencer for the 3-tap adaptive FIR/LMS: flush, train, track, freeze.
// Latency: state and control outputs registered (1 cycle); o_sample_en combinational.
// Backpressure: o_ready low in IDLE/FLUSH; samples accepted every cycle otherwise.
module lms_adapt_ctrl
  import lms_ctrl_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_CNT    = 16,
  parameter int AVG_SHIFT = AVG_SHIFT_DEF,
  parameter int HOLD_CNT  = HOLD_CNT_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_freeze,
  input  logic [NB_CNT-1:0]  i_train_len,
  input  logic [NB_DATA-1:0] i_thresh,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_sample_en,
  input  logic               i_err_valid,
  input  logic [NB_DATA-1:0] i_error,
  output logic               o_flush,
  output logic               o_adapt_en,
  output logic               o_converged,
  output logic               o_timeout,
  output logic [NB_DATA-1:0] o_err_avg,
  output logic [2:0]         o_state
);

  localparam int HW = $clog2(HOLD_CNT + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [HW-1:0] HOLD_TGT  = HW'(HOLD_CNT);
  localparam logic [FW-1:0] FLUSH_END = FW'(FLUSH_CYC - 1);

  state_t             state;
  state_t             nxt_state;
  logic [NB_CNT-1:0]  samp_cnt;
  logic [NB_CNT-1:0]  samp_cnt_nxt;
  logic [NB_CNT-1:0]  len_eff;
  logic [HW-1:0]      hold_cnt;
  logic [HW-1:0]      hold_nxt;
  logic [FW-1:0]      flush_cnt;
  logic [NB_DATA-1:0] avg_nxt;
  logic               in_run;
  logic               avg_en;
  logic               train_upd;
  logic               conv_hit;
  logic               len_hit;
  logic               diverged;
  logic               go_flush;

  assign o_sample_en = i_valid & o_ready;
  assign o_state     = state;

  err_avg_lpf #(
    .NB_DATA   (NB_DATA),
    .AVG_SHIFT (AVG_SHIFT)
  ) u_err_avg (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load_max (go_flush),
    .en       (avg_en),
    .error    (i_error),
    .avg      (o_err_avg),
    .avg_nxt  (avg_nxt)
  );

  // Command decode, training counters look-ahead and next-state selection.
  always_comb begin
    len_eff      = (i_train_len == '0) ? NB_CNT'(1) : i_train_len;
    in_run       = state inside {ST_TRAIN, ST_TRACK, ST_FROZEN};
    avg_en       = i_err_valid & in_run;
    // Counters only advance on a sample that leaves the FSM in TRAIN or finishes it.
    train_upd    = (state == ST_TRAIN) & i_err_valid & ~i_stop & ~i_start & ~i_freeze;
    samp_cnt_nxt = samp_cnt + NB_CNT'(1);
    hold_nxt     = (avg_nxt < i_thresh) ? hold_cnt + HW'(1) : '0;
    conv_hit     = train_upd & (hold_nxt == HOLD_TGT);
    len_hit      = train_upd & (samp_cnt_nxt >= len_eff);
    diverged     = o_converged & ({1'b0, o_err_avg} > {i_thresh, 1'b0});
    go_flush     = ~i_stop & (i_start | ((state == ST_TRACK) & ~i_freeze & diverged));

    nxt_state = state;
    if (i_stop) begin
      nxt_state = ST_IDLE;
    end else if (i_start) begin
      nxt_state = ST_FLUSH;
    end else if (i_freeze && (state inside {ST_TRAIN, ST_TRACK})) begin
      nxt_state = ST_FROZEN;
    end else begin
      case (state)
        ST_FLUSH:  if (flush_cnt == FLUSH_END) nxt_state = ST_TRAIN;
        ST_TRAIN:  if (conv_hit || len_hit) nxt_state = ST_TRACK;
        ST_TRACK:  if (diverged) nxt_state = ST_FLUSH;
        ST_FROZEN: if (!i_freeze) nxt_state = ST_TRACK;
        default:   nxt_state = state;
      endcase
    end
  end

  // State register, registered state decode, counters and sticky flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_flush     <= 1'b0;
      o_ready     <= 1'b0;
      o_adapt_en  <= 1'b0;
      o_converged <= 1'b0;
      o_timeout   <= 1'b0;
      samp_cnt    <= '0;
      hold_cnt    <= '0;
      flush_cnt   <= '0;
    end else begin
      state      <= nxt_state;
      o_flush    <= (nxt_state == ST_FLUSH);
      o_ready    <= (nxt_state inside {ST_TRAIN, ST_TRACK, ST_FROZEN});
      o_adapt_en <= (nxt_state inside {ST_TRAIN, ST_TRACK});
      if (go_flush) begin
        flush_cnt   <= '0;
        samp_cnt    <= '0;
        hold_cnt    <= '0;
        o_converged <= 1'b0;
        o_timeout   <= 1'b0;
      end else begin
        if (state == ST_FLUSH) begin
          flush_cnt <= flush_cnt + FW'(1);
        end
        if (train_upd) begin
          samp_cnt <= samp_cnt_nxt;
          hold_cnt <= hold_nxt;
          if (conv_hit) begin
            o_converged <= 1'b1;
          end else if (len_hit) begin
            o_timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule
